// File: rtl/uart_tx_pkg.sv
// Shared register map, CTRL/STATUS bit positions and CTRL field layout for the UART transmit CSR block.
package uart_tx_pkg;

    localparam logic [31:0] OFF_TXDATA = 32'h00;
    localparam logic [31:0] OFF_CTRL   = 32'h04;
    localparam logic [31:0] OFF_STATUS = 32'h08;
    localparam logic [31:0] OFF_BAUD   = 32'h0C;
    localparam logic [31:0] OFF_IRQ_EN = 32'h10;

    localparam int CTRL_TX_EN      = 0;
    localparam int CTRL_TWO_STOP   = 1;
    localparam int CTRL_ODD_PARITY = 2;
    localparam int CTRL_PARITY_EN  = 3;
    localparam int CTRL_FLUSH      = 4;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_OVERFLOW = 3;
    localparam int STAT_CFG_WR   = 4;

    localparam logic [15:0] BAUD_RST_DEFAULT = 16'd868;

    typedef struct packed {
        logic parity_en;
        logic odd_parity;
        logic two_stop;
        logic tx_en;
    } ctrl_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit character FIFO: registered storage, exact occupancy count, flush overrides push and pop.
module uart_tx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned AW = $clog2(FIFO_DEPTH),
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & ~flush & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_csr.sv
// UART transmit CSR block: bus-mapped registers in front of the transmit FIFO.
// Define UART_TX_IRQ_EN to build the IRQ_EN register and the level interrupt.
module uart_tx_csr
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter logic [15:0] BAUD_RST   = BAUD_RST_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              tx_busy,
    output logic              tx_en_r,
    output logic              two_stop_r,
    output logic              odd_parity_r,
    output logic              parity_en_r,
    output logic [15:0]       baud_div_r,
    output logic              irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    ctrl_t       ctrl_q, ctrl_d;
    logic        ovf_q, ovf_d;
    logic        cfg_q, cfg_d;
    logic [15:0] baud_q, baud_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] offset, status_word, irq_en_word;
    logic        wr_txdata, wr_ctrl, wr_status, wr_baud, wr_irq_en;
    logic        fifo_empty, fifo_full, pop, flush;
    logic [CW-1:0] fifo_count;
    logic        unused_ok;

    assign offset    = addr - BASE_ADDR;
    assign wr_txdata = wr_en & (offset == OFF_TXDATA);
    assign wr_ctrl   = wr_en & (offset == OFF_CTRL);
    assign wr_status = wr_en & (offset == OFF_STATUS);
    assign wr_baud   = wr_en & (offset == OFF_BAUD);
    assign wr_irq_en = wr_en & (offset == OFF_IRQ_EN);
    assign flush     = wr_ctrl & wdata[CTRL_FLUSH];

    // Transmit handshake: tx_data is a character whenever tx_valid is high; it is
    // consumed on any rising edge where tx_valid and tx_ready are both high.
    assign tx_valid = ~fifo_empty & ctrl_q.tx_en;
    assign pop      = tx_valid & tx_ready;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txdata),
        .push_data (wdata[DATA_W-1:0]),
        .pop       (pop),
        .flush     (flush),
        .head_data (tx_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign status_word = {16'h0, 8'(fifo_count), 3'b0, cfg_q, ovf_q,
                          tx_busy | ~fifo_empty, fifo_full, fifo_empty};

    always_comb begin
        ctrl_d  = ctrl_q;
        baud_d  = baud_q;
        rdata_d = rdata_q;
        if (wr_ctrl) begin
            ctrl_d = ctrl_t'(wdata[CTRL_PARITY_EN:CTRL_TX_EN]);
        end
        if (wr_baud && (wdata[15:0] != 16'h0)) begin
            baud_d = wdata[15:0];
        end
        // Sticky bits: a same-cycle set beats the write-one-to-clear.
        ovf_d = (wr_txdata & fifo_full & ~pop & ~flush)
              | (ovf_q & ~(wr_status & wdata[STAT_OVERFLOW]));
        cfg_d = wr_ctrl | (cfg_q & ~(wr_status & wdata[STAT_CFG_WR]));
        if (rd_en) begin
            case (offset)
                OFF_CTRL:   rdata_d = {28'h0, ctrl_q};
                OFF_STATUS: rdata_d = status_word;
                OFF_BAUD:   rdata_d = {16'h0, baud_q};
                OFF_IRQ_EN: rdata_d = irq_en_word;
                default:    rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q  <= '0;
            ovf_q   <= 1'b0;
            cfg_q   <= 1'b0;
            baud_q  <= BAUD_RST;
            rdata_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
            cfg_q   <= cfg_d;
            baud_q  <= baud_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef UART_TX_IRQ_EN
    logic [1:0] irq_en_q, irq_en_d;
    logic       irq_q, irq_d;

    always_comb begin
        irq_en_d = wr_irq_en ? wdata[1:0] : irq_en_q;
        irq_d    = (irq_en_q[0] & fifo_empty & ctrl_q.tx_en) | (irq_en_q[1] & ovf_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en_word = {30'h0, irq_en_q};
    assign irq         = irq_q;
    assign unused_ok   = ^wdata[31:16];
`else
    assign irq_en_word = 32'h0;
    assign irq         = 1'b0;
    assign unused_ok   = ^{wdata[31:16], wr_irq_en};
`endif

    assign rdata        = rdata_q;
    assign tx_en_r      = ctrl_q.tx_en;
    assign two_stop_r   = ctrl_q.two_stop;
    assign odd_parity_r = ctrl_q.odd_parity;
    assign parity_en_r  = ctrl_q.parity_en;
    assign baud_div_r   = baud_q;

endmodule

// File: tb/tb_uart_tx_csr.sv
// Directed bench for uart_tx_csr: register access, FIFO ordering, overflow, flush, reset.
module tb_uart_tx_csr;

    localparam logic [31:0] A_TXDATA = 32'h00;
    localparam logic [31:0] A_CTRL   = 32'h04;
    localparam logic [31:0] A_STATUS = 32'h08;
    localparam logic [31:0] A_BAUD   = 32'h0C;
    localparam logic [31:0] A_IRQ_EN = 32'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_en_r, two_stop_r, odd_parity_r, parity_en_r;
    logic [15:0] baud_div_r;
    logic        irq;

    int assert_cnt = 0;
    int fail_cnt = 0;
    logic [31:0] rv;

    uart_tx_csr dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .tx_en_r      (tx_en_r),
        .two_stop_r   (two_stop_r),
        .odd_parity_r (odd_parity_r),
        .parity_en_r  (parity_en_r),
        .baud_div_r   (baud_div_r),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
            $error("%s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        rd_en = 1'b1;
        addr  = a;
        tick();
        rd_en = 1'b0;
        d     = rdata;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_rdata", rdata, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_ctrl", {28'h0, parity_en_r, odd_parity_r, two_stop_r, tx_en_r}, 32'h0);
        check("rst_baud", {16'h0, baud_div_r}, 32'd868);
        check("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        rd(A_BAUD, rv);
        check("rd_baud_rst", rv, 32'd868);
        rd(A_STATUS, rv);
        check("rd_status_rst", rv, 32'h0000_0001);

        // Enable, cfg_written sticky and its W1C
        wr(A_CTRL, 32'h1);
        check("tx_en_r_set", {31'h0, tx_en_r}, 32'h1);
        rd(A_STATUS, rv);
        check("status_cfg_wr", rv, 32'h0000_0011);
        wr(A_STATUS, 32'h10);
        rd(A_STATUS, rv);
        check("status_cfg_w1c", rv, 32'h0000_0001);

        // Three characters out in order
        wr_en = 1'b1; addr = A_TXDATA; wdata = 32'h41;
        check("no_bypass", {31'h0, tx_valid}, 32'h0);
        tick();
        wr_en = 1'b0;
        check("first_visible", {31'h0, tx_valid}, 32'h1);
        wr(A_TXDATA, 32'h42);
        wr(A_TXDATA, 32'h43);
        rd(A_STATUS, rv);
        check("status_cnt3", rv, 32'h0000_0304);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("drain_valid", {31'h0, tx_valid}, 32'h1);
            check("drain_data", {24'h0, tx_data}, 32'h41 + i);
            tick();
        end
        tx_ready = 1'b0;
        check("drain_done_valid", {31'h0, tx_valid}, 32'h0);
        rd(A_STATUS, rv);
        check("status_drained", rv, 32'h0000_0001);

        // Overflow with transmitter disabled
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 9; i++) wr(A_TXDATA, 32'h50 + i);
        check("full_no_valid", {31'h0, tx_valid}, 32'h0);
        rd(A_STATUS, rv);
        check("status_ovf", rv, 32'h0000_081E);
        wr(A_STATUS, 32'h8);
        rd(A_STATUS, rv);
        check("status_ovf_w1c", rv, 32'h0000_0816);

        // Push and pop on a full FIFO in the same cycle
        wr(A_CTRL, 32'h1);
        check("full_head", {24'h0, tx_data}, 32'h50);
        tx_ready = 1'b1;
        wr(A_TXDATA, 32'h99);
        tx_ready = 1'b0;
        rd(A_STATUS, rv);
        check("status_full_pp", rv, 32'h0000_0816);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("pp_valid", {31'h0, tx_valid}, 32'h1);
            check("pp_data", {24'h0, tx_data}, (i < 7) ? 32'h51 + i : 32'h99);
            tick();
        end
        tx_ready = 1'b0;
        check("pp_done_valid", {31'h0, tx_valid}, 32'h0);

        // Flush beats a same-cycle pop
        for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'h60 + i);
        tx_ready = 1'b1;
        wr(A_CTRL, 32'h11);
        tx_ready = 1'b0;
        check("flush_valid", {31'h0, tx_valid}, 32'h0);
        rd(A_STATUS, rv);
        check("status_flush", rv, 32'h0000_0011);
        rd(A_CTRL, rv);
        check("ctrl_flush_reads0", rv, 32'h0000_0001);

        // Baud divisor: zero ignored, low half loaded
        wr(A_BAUD, 32'h0);
        check("baud_zero_ignored", {16'h0, baud_div_r}, 32'd868);
        wr(A_BAUD, 32'h1234_0010);
        rd(A_BAUD, rv);
        check("baud_loaded", rv, 32'h0000_0010);

        // Other fields, unmapped and write-only addresses
        wr(A_CTRL, 32'hE);
        check("ctrl_fields", {28'h0, parity_en_r, odd_parity_r, two_stop_r, tx_en_r}, 32'hE);
        wr(A_CTRL, 32'h1);
        wr(32'h14, 32'hFFFF_FFFF);
        rd(32'h14, rv);
        check("unmapped_rd", rv, 32'h0);
        rd(A_TXDATA, rv);
        check("txdata_rd", rv, 32'h0);
        check("unmapped_no_push", {31'h0, tx_valid}, 32'h0);

        // Busy follows the transmitter when empty; rdata holds without rd_en
        tx_busy = 1'b1;
        rd(A_STATUS, rv);
        tx_busy = 1'b0;
        check("status_tx_busy", rv, 32'h0000_0015);
        tick();
        check("rdata_hold", rdata, 32'h0000_0015);

`ifdef UART_TX_IRQ_EN
        wr(A_IRQ_EN, 32'h1);
        tick();
        check("irq_empty", {31'h0, irq}, 32'h1);
        wr(A_TXDATA, 32'h70);
        tick();
        check("irq_after_push", {31'h0, irq}, 32'h0);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();
        check("irq_after_drain", {31'h0, irq}, 32'h1);
        rd(A_IRQ_EN, rv);
        check("irq_en_rd", rv, 32'h1);
        wr(A_IRQ_EN, 32'h0);
        tick();
        check("irq_disabled", {31'h0, irq}, 32'h0);
`else
        wr(A_IRQ_EN, 32'h3);
        rd(A_IRQ_EN, rv);
        check("irq_en_absent", rv, 32'h0);
        check("irq_tied", {31'h0, irq}, 32'h0);
`endif

        // Reset in the middle of traffic
        wr(A_TXDATA, 32'h80);
        wr(A_TXDATA, 32'h81);
        check("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_baud", {16'h0, baud_div_r}, 32'd868);
        check("mid_rst_tx_en", {31'h0, tx_en_r}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        rd(A_STATUS, rv);
        check("post_rst_status", rv, 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_csr.md
UART_TX_CSR -- requirements
Module: uart_tx_csr

Interface
REQ-001 Parameter DATA_W, default 8, transmit character width, legal range 5..8.
REQ-002 Parameter FIFO_DEPTH, default 8, transmit FIFO entries, power of two, 2..64.
REQ-003 Parameter BASE_ADDR, default 32'h0, byte address of register 0.
REQ-004 Parameter BAUD_RST, default 16'd868, reset value of the baud divisor.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 wr_en  in  1  bus write strobe, one write per cycle.
REQ-008 rd_en  in  1  bus read strobe.
REQ-009 addr  in  32  bus byte address.
REQ-010 wdata  in  32  bus write data.
REQ-011 rdata  out  32  registered read data.
REQ-012 tx_data  out  DATA_W  FIFO head character to the transmitter.
REQ-013 tx_valid  out  1  tx_data valid.
REQ-014 tx_ready  in  1  transmitter accepts tx_data when high with tx_valid.
REQ-015 tx_busy  in  1  transmitter shifting a frame.
REQ-016 tx_en_r, two_stop_r, odd_parity_r, parity_en_r  out  1 each  CTRL fields.
REQ-017 baud_div_r  out  16  current baud divisor.
REQ-018 irq  out  1  level interrupt.

Function
REQ-019 Map: BASE+0x0 TXDATA (W), +0x4 CTRL (RW), +0x8 STATUS (R/W1C), +0xC BAUD (RW), +0x10 IRQ_EN (RW); other addresses read 0, writes ignored.
REQ-020 CTRL bits: [0] tx_en, [1] two_stop, [2] odd_parity, [3] parity_en, [4] flush (write-only, reads 0).
REQ-021 STATUS bits: [0] empty, [1] full, [2] busy (tx_busy | ~empty), [3] overflow (sticky, W1C), [4] cfg_written (sticky, W1C), [15:8] entry count.
REQ-022 Read: rdata updates one cycle after rd_en with value sampled at rd_en; rdata holds otherwise.
REQ-023 TXDATA write pushes wdata[DATA_W-1:0]; visible on tx_valid no earlier than next cycle (no bypass).
REQ-024 Push accepted when not full, or when full and a pop occurs the same cycle; otherwise dropped and overflow set.
REQ-025 Pop occurs when tx_valid & tx_ready; tx_valid = ~empty & tx_en_r.
REQ-026 Simultaneous push and pop: count unchanged, order preserved.
REQ-027 Pointers wrap modulo FIFO_DEPTH; count is exact 0..FIFO_DEPTH.
REQ-028 CTRL write updates fields next cycle and sets cfg_written; flush=1 empties FIFO next cycle and overrides any push/pop that cycle.
REQ-029 BAUD write of 0 is ignored; nonzero wdata[15:0] loads baud_div_r.
REQ-030 Clearing tx_en holds FIFO contents; tx_valid drops next cycle.
REQ-031 W1C write with bit=1 clears the sticky bit unless set by the same-cycle event (set wins).

Reset
REQ-032 On reset: FIFO empty, CTRL fields 0, overflow 0, cfg_written 0, IRQ_EN 0, baud_div_r=BAUD_RST, rdata=0, tx_valid=0, irq=0.
REQ-033 Reset mid-transfer discards FIFO contents with no partial pop.

Configuration
REQ-034 Macro UART_TX_IRQ_EN defined: IRQ_EN bits [0] empty_ie, [1] ovf_ie; irq = (empty_ie & empty & tx_en_r) | (ovf_ie & overflow), registered.
REQ-035 Macro undefined: irq tied 0, IRQ_EN reads 0, writes ignored; all other behaviour identical.

Structure
REQ-036 Package uart_tx_pkg holds register offsets, CTRL/STATUS bit indices, ctrl_t packed struct and BAUD_RST default.
REQ-037 Sub-module uart_tx_fifo (params DATA_W, FIFO_DEPTH; push/pop/flush, empty/full/count) instantiated once.

Verification
REQ-038 Reset, read BAUD -> rdata=868 one cycle after rd_en; STATUS -> 0x0000_0001.
REQ-039 CTRL=0x1, push 0x41,0x42,0x43, tx_ready=1 -> tx_data 0x41,0x42,0x43 in order, then tx_valid=0, count=0.
REQ-040 tx_en=0, push 9 chars into depth-8 -> STATUS full=1, overflow=1, count=8; W1C 0x8 -> overflow=0.
REQ-041 Full FIFO, tx_en=1, push and pop same cycle -> push accepted, count stays 8, no overflow.
REQ-042 3 entries, CTRL=0x11 with same-cycle pop -> next cycle empty=1, count=0; BAUD write 0 -> baud_div_r unchanged.
REQ-043 UART_TX_IRQ_EN defined, IRQ_EN=0x1, tx_en=1, FIFO drains -> irq=1 cycle after empty; push -> irq=0 cycle after push.
